ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Accepts one command byte, runs the
// request-to-send sequence on the open-drain clock/data lines, shifts the
// frame out on device clock falls and reports the device ACK.
// Optional build macro: PS2_TX_RETRY_EN (automatic retry on NACK/timeout,
// adds the retry_cnt output).
//
// Handshake: tx_data is accepted on a clock edge where tx_valid and
// tx_ready are both 1; tx_ready is high only in IDLE, and tx_valid is
// ignored otherwise.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 20000,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
`ifdef PS2_TX_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

  localparam int INHIBIT_CYC = (CLK_HZ / 1000000) * INHIBIT_US;
  localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int CNT_W       = $clog2(INHIBIT_CYC + 1);
  localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_XFER, S_ACK, S_WAIT_REL, S_DONE
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [3:0]         bit_cnt, bit_cnt_d;
  logic [9:0]         shreg, shreg_d;
  logic               ack_reg, ack_reg_d;
  logic               data_oe_d, clk_oe_d, done_d, ack_ok_d, err_d;
  logic               failed, failed_tmo, tmo_hit;
  logic [2:0]         clk_s, data_s;
  logic               dev_fall;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] byte_q, byte_d;
  logic [1:0] retry_d;
`else
  // Retries are compiled out; MAX_RETRY only shapes the retry build.
  if (MAX_RETRY > 3) begin : g_retry_unused
  end
`endif

  assign dev_fall   = clk_s[2] & ~clk_s[1];
  // timer counts cycles elapsed since the last fall, so done lands exactly
  // TIMEOUT_CYC cycles after it; a fall always wins over the timeout
  assign tmo_hit    = ~dev_fall && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign rx_inhibit = busy;

  // three-stage synchronisers on both raw pin levels (idle lines read high)
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s  <= 3'b111;
      data_s <= 3'b111;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk_in};
      data_s <= {data_s[1:0], ps2_data_in};
    end
  end

  // next-state and next-output logic; every pin and status output is registered
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    timer_d    = timer;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    ack_reg_d  = ack_reg;
    data_oe_d  = ps2_data_oe;
    done_d     = 1'b0;
    ack_ok_d   = 1'b0;
    err_d      = 1'b0;
    failed     = 1'b0;
    failed_tmo = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_cnt;
`endif
    case (state)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = CNT_W'(INHIBIT_CYC);
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d  = tx_data;
          retry_d = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        // cnt==1 marks the last of INHIBIT_CYC cycles with only clock held
        if (cnt <= CNT_W'(1)) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_RTS: begin
        bit_cnt_d = 4'd0;
        timer_d   = TMR_W'(1);
        state_d   = S_XFER;
      end
      S_XFER: begin
        if (dev_fall) begin
          data_oe_d = ~shreg[0];
          shreg_d   = {1'b0, shreg[9:1]};
          bit_cnt_d = bit_cnt + 1'b1;
          timer_d   = TMR_W'(1);
          if (bit_cnt == 4'd9) state_d = S_ACK;
        end else if (tmo_hit) begin
          failed     = 1'b1;
          failed_tmo = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (dev_fall) begin
          ack_reg_d = ~data_s[1];
          timer_d   = TMR_W'(1);
          state_d   = S_WAIT_REL;
        end else if (tmo_hit) begin
          failed     = 1'b1;
          failed_tmo = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_WAIT_REL: begin
        data_oe_d = 1'b0;
        if (clk_s[2] && data_s[2]) begin
          if (ack_reg) begin
            done_d   = 1'b1;
            ack_ok_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            failed = 1'b1;
          end
        end else if (tmo_hit) begin
          failed     = 1'b1;
          failed_tmo = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_DONE: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // a NACK or timeout releases the lines and either retries or finishes
    if (failed) begin
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt < 2'(MAX_RETRY)) begin
        retry_d = retry_cnt + 1'b1;
        shreg_d = {1'b1, ~^byte_q, byte_q};
        cnt_d   = CNT_W'(INHIBIT_CYC);
        state_d = S_INHIBIT;
      end else
`endif
      begin
        done_d  = 1'b1;
        err_d   = failed_tmo;
        state_d = S_DONE;
      end
    end

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
  end

  // state and registered outputs; reset releases both lines immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ack_reg     <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q      <= '0;
      retry_cnt   <= '0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      timer       <= timer_d;
      bit_cnt     <= bit_cnt_d;
      shreg       <= shreg_d;
      ack_reg     <= ack_reg_d;
      tx_ready    <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      done        <= done_d;
      ack_ok      <= ack_ok_d;
      err_timeout <= err_d;
`ifdef PS2_TX_RETRY_EN
      byte_q      <= byte_d;
      retry_cnt   <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain line model, a simple PS/2 device
// model that clocks the frame and samples bits, and scoreboard queues for
// the device-sampled bits and the done/ack/timeout results.
module tb_ps2_host_tx;

  localparam int CLK_HZ      = 50000000;
  localparam int TIMEOUT_US  = 100;
  localparam int INHIBIT_CYC = (CLK_HZ / 1000000) * 120;
  localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int SYNC_LAT    = 2;    // pin edge to synchronised fall, in clocks
  localparam int DEV_H       = 150;  // device clock half period, in clocks

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and open-drain lines ----------------
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, rx_inhibit, done, ack_ok, err_timeout;
  logic       dev_clk_low, dev_data_low;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .rx_inhibit(rx_inhibit), .done(done), .ack_ok(ack_ok),
    .err_timeout(err_timeout)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];   // bits the device should sample, start bit first
  logic [1:0] res_q[$];   // {ack_ok, err_timeout} expected at done
  int tests_run = 0;
  int tests_failed = 0;
  int last_fall_cyc = 0;
  int done_cyc = 0;
  bit scramble = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected frame: start 0, d0..d7, odd parity, stop 1; first n device samples
  task automatic push_bits(input logic [7:0] b, input int nsamp);
    logic [9:0] frame;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    frame = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    exp_q.push_back(1'b0);
    for (int i = 0; i < nsamp; i++) exp_q.push_back(frame[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic dev_sample(input string tag);
    logic [0:0] e;
    check({tag, "_avail"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, ps2_data_in, e);
    end
  endtask

  // device: samples the start bit, then clocks nfalls falls, sampling the
  // bit presented after each fall; optionally pulls data low for the ACK
  task automatic dev_run(input int nfalls, input bit do_ack);
    repeat (DEV_H) @(negedge clk);
    dev_sample("dev_start");
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (DEV_H) @(negedge clk);
      if (k <= 10) dev_sample("dev_bit");
      dev_clk_low = 1'b0;
      if (k == 10 && do_ack) dev_data_low = 1'b1;
      repeat (DEV_H) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  // called at the first negedge after accept: inhibit length then RTS length
  task automatic measure_inhibit();
    int n, m;
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 20000) begin
      n++;
      @(negedge clk);
      if (scramble) tx_data = 8'($urandom_range(0, 255));
    end
    check("inhibit_len", n, INHIBIT_CYC);
    m = 0;
    while (ps2_clk_oe && ps2_data_oe && m < 10) begin
      m++;
      @(negedge clk);
      if (scramble) tx_data = 8'($urandom_range(0, 255));
    end
    check("rts_len", m, 1);
    check("start_held", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task automatic wait_done(input logic [7:0] next_byte);
    bit got;
    logic [1:0] r;
    got = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        check("res_avail", (res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("ack_err", {ack_ok, err_timeout}, r);
        end
        check("released_at_done", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("ready_low_at_done", tx_ready, 0);
        if (scramble) begin
          tx_data = next_byte;
          scramble = 1'b0;
        end
      end else if (scramble) begin
        tx_data = 8'($urandom_range(0, 255));
      end
    end
    check("done_seen", got, 1);
    @(negedge clk);
    check("ready_after_done", tx_ready, 1);
    check("done_one_cycle", done, 0);
  endtask

  task automatic issue(input logic [7:0] b, input int nsamp, input bit has_res, input logic [1:0] res);
    tx_data = b;
    tx_valid = 1'b1;
    push_bits(b, nsamp);
    if (has_res) res_q.push_back(res);
    @(negedge clk);
    check("accepted", busy, 1);
    tx_valid = 1'b0;
    measure_inhibit();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_cnt;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_low", tx_ready, 0);
    check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", tx_ready, 1);
    check("post_reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("post_reset_status", {busy, rx_inhibit, done, ack_ok, err_timeout}, 5'b0);

    // 0xED with ACK, tx_valid held and tx_data changing while busy
    tx_data = 8'hED;
    tx_valid = 1'b1;
    push_bits(8'hED, 10);
    res_q.push_back(2'b10);
    @(negedge clk);
    check("ed_accept", busy, 1);
    check("ed_inhibit_flag", rx_inhibit, 1);
    scramble = 1'b1;
    measure_inhibit();
    fork
      dev_run(11, 1'b1);
      wait_done(8'h00);
    join
    // tx_ready is high now with tx_valid still up: 0x00 goes in this cycle
    push_bits(8'h00, 10);
    res_q.push_back(2'b00);
    @(negedge clk);
    check("hold_accept", busy, 1);
    tx_valid = 1'b0;
    measure_inhibit();
    fork
      dev_run(11, 1'b0);
      wait_done(8'h00);
    join

    // device stops clocking after 4 falls
    issue(8'hA5, 4, 1'b1, 2'b01);
    fork
      dev_run(4, 1'b0);
      wait_done(8'h00);
    join
    check("timeout_latency", done_cyc - last_fall_cyc, SYNC_LAT + TIMEOUT_CYC);

    // reset during bit 5 of 0xFF
    issue(8'hFF, 5, 1'b0, 2'b00);
    dev_run(5, 1'b0);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset_mid_status", {busy, done, tx_ready}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_reset", done_cnt, 0);
    check("ready_after_reset", tx_ready, 1);

    // clean 0xF4 after the aborted transfer
    issue(8'hF4, 10, 1'b1, 2'b10);
    fork
      dev_run(11, 1'b1);
      wait_done(8'h00);
    join

    check("bits_drained", exp_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
